// File: rtl/h14rx_pkg.sv
// Shared definitions for the HDMI 1.4 receive channel: TMDS control tokens,
// aligner state encoding and the per-symbol decode function.
package h14rx_pkg;

    localparam logic [9:0] CtlTok0 = 10'h354;
    localparam logic [9:0] CtlTok1 = 10'h0AB;
    localparam logic [9:0] CtlTok2 = 10'h154;
    localparam logic [9:0] CtlTok3 = 10'h2AB;

    typedef enum logic {
        SEARCH,
        LOCKED
    } align_state_e;

    function automatic logic is_ctl_token(input logic [9:0] q);
        return (q == CtlTok0) || (q == CtlTok1) || (q == CtlTok2) || (q == CtlTok3);
    endfunction

    // Result is {de, c[1:0], d[7:0]}; c is 00 for data, d is 0 for tokens.
    function automatic logic [10:0] tmds_decode(input logic [9:0] q);
        logic [7:0]  v;
        logic [7:0]  dv;
        logic [10:0] r;
        v     = q[9] ? ~q[7:0] : q[7:0];
        dv    = '0;
        dv[0] = v[0];
        for (int i = 1; i < 8; i++) begin
            dv[i] = q[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        end
        case (q)
            CtlTok0: r = {1'b0, 2'b00, 8'h00};
            CtlTok1: r = {1'b0, 2'b01, 8'h00};
            CtlTok2: r = {1'b0, 2'b10, 8'h00};
            CtlTok3: r = {1'b0, 2'b11, 8'h00};
            default: r = {1'b1, 2'b00, dv};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/h14rx_tmds_aligner.sv
// Symbol boundary recovery: hunts across the ten bit offsets for a run of
// control tokens, then holds the offset while tokens keep re-confirming it.
module h14rx_tmds_aligner
    import h14rx_pkg::*;
#(
    parameter int TokenRun     = 8,
    parameter int SearchWindow = 4096
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic [9:0] sym_i,
    output logic [9:0] q,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int RunW   = $clog2(TokenRun + 1);
    localparam int TimerW = $clog2(SearchWindow);
    localparam logic [RunW-1:0]   RunMax   = RunW'(TokenRun);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(SearchWindow - 1);

    logic [9:0]        s0;
    logic [9:0]        s1;
    logic [19:0]       window;
    align_state_e      state;
    logic [RunW-1:0]   run;
    logic [RunW-1:0]   run_inc;
    logic [TimerW-1:0] timer;
    logic              run_done;
    logic              timer_done;

    // s0 holds the older word, so its bits are earliest in the window.
    assign window = {s1, s0};
    assign q      = window[offset +: 10];

    always_comb begin
        run_inc = '0;
        if (is_ctl_token(q)) begin
            run_inc = (run == RunMax) ? RunMax : run + 1'b1;
        end
    end

    assign run_done   = (run_inc == RunMax);
    assign timer_done = (timer == TimerMax);

    // A completed run always takes priority over a timer expiry, so a run that
    // finishes on the last cycle of a window neither slips nor drops lock.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            s0     <= '0;
            s1     <= '0;
            state  <= SEARCH;
            locked <= 1'b0;
            run    <= '0;
            timer  <= '0;
            offset <= 4'd0;
        end else begin
            s1 <= sym_i;
            s0 <= s1;
            if (run_done) begin
                state  <= LOCKED;
                locked <= 1'b1;
                run    <= run_inc;
                timer  <= '0;
            end else if (timer_done) begin
                run   <= '0;
                timer <= '0;
                if (state == SEARCH) begin
                    offset <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                end else begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            end else begin
                run   <= run_inc;
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: rtl/h14rx_tmds_chan_decode.sv
// One HDMI 1.4 data channel: word alignment followed by a registered TMDS
// decode of the aligned symbol into de / c / d.
module h14rx_tmds_chan_decode
    import h14rx_pkg::*;
#(
    parameter int TokenRun     = 8,
    parameter int SearchWindow = 4096
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic [9:0] sym_i,
    output logic       locked,
    output logic [3:0] offset,
    output logic       de,
    output logic [1:0] c,
    output logic [7:0] d
);

    logic [9:0]  q;
    logic [10:0] dec_r;

    h14rx_tmds_aligner #(
        .TokenRun    (TokenRun),
        .SearchWindow(SearchWindow)
    ) u_aligner (
        .pixel_clk(pixel_clk),
        .rst      (rst),
        .sym_i    (sym_i),
        .q        (q),
        .locked   (locked),
        .offset   (offset)
    );

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            dec_r <= '0;
        end else begin
            dec_r <= tmds_decode(q);
        end
    end

    // Gating with the registered lock lines up the first valid output with
    // the edge that declares lock, and blanks everything while unlocked.
    assign de = locked & dec_r[10];
    assign c  = locked ? dec_r[9:8] : 2'b00;
    assign d  = locked ? dec_r[7:0] : 8'h00;

endmodule

// File: tb/tb_h14rx_tmds_chan_decode.sv
// Directed bench for h14rx_tmds_chan_decode: lock, decode, slip, unlock,
// offset wrap and reset recovery on hand-built serial streams.
module tb_h14rx_tmds_chan_decode;
    import h14rx_pkg::*;

    logic       pixel_clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sym_i = '0;
    logic       locked;
    logic [3:0] offset;
    logic       de;
    logic [1:0] c;
    logic [7:0] d;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dly = 0;
    logic [9:0]  prev_src = '0;
    logic [10:0] pipe1 = '0;
    logic [10:0] pipe2 = '0;
    logic [10:0] pipe3 = '0;

    h14rx_tmds_chan_decode #(.TokenRun(8), .SearchWindow(4096)) dut (
        .pixel_clk(pixel_clk),
        .rst      (rst),
        .sym_i    (sym_i),
        .locked   (locked),
        .offset   (offset),
        .de       (de),
        .c        (c),
        .d        (d)
    );

    always #5 pixel_clk = ~pixel_clk;

    function automatic logic [10:0] tok_int(input logic [1:0] cv);
        return {1'b0, cv, 8'h00};
    endfunction

    function automatic logic [10:0] dat_int(input logic [7:0] b);
        return {1'b1, 2'b00, b};
    endfunction

    function automatic logic tb_is_tok(input logic [9:0] x);
        return (x == 10'h354) || (x == 10'h0AB) || (x == 10'h154) || (x == 10'h2AB);
    endfunction

    // Source-side encoder: picks the first of four inv/xor modes whose symbol is not a token.
    function automatic logic [9:0] encode(input logic [7:0] b, input logic [1:0] mode);
        logic [7:0] m;
        logic [9:0] q;
        logic [1:0] mm;
        q = '0;
        for (int k = 0; k < 4; k++) begin
            mm   = mode ^ 2'(k);
            m    = '0;
            m[0] = b[0];
            for (int i = 1; i < 8; i++) m[i] = mm[1] ? (m[i-1] ^ b[i]) : ~(m[i-1] ^ b[i]);
            q = {mm[0], mm[1], mm[0] ? ~m : m};
            if (!tb_is_tok(q)) break;
        end
        return q;
    endfunction

    // Serialises src behind a dly-bit lead-in and records what the output should carry.
    task automatic step(input logic [9:0] src, input logic [10:0] intent);
        logic [19:0] pair;
        pair     = {src, prev_src};
        sym_i    = pair[10-dly +: 10];
        prev_src = src;
        @(posedge pixel_clk);
        #1;
        pipe3 = pipe2;
        pipe2 = pipe1;
        pipe1 = intent;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(10'h000, 11'h000);
        rst      = 1'b0;
        cyc      = 0;
        prev_src = '0;
        pipe1    = '0;
        pipe2    = '0;
        pipe3    = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %0h expected 0", locked); end
        checks++; if (de !== 1'b0) begin errors++; $display("[TB] FAIL reset_de: got %0h expected 0", de); end
        checks++; if (c !== 2'b00) begin errors++; $display("[TB] FAIL reset_c: got %0h expected 0", c); end
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_d: got %0h expected 0", d); end
        checks++; if (offset !== 4'd0) begin errors++; $display("[TB] FAIL reset_offset: got %0d expected 0", offset); end
    endtask

    task automatic test_lock();
        do_reset();
        dly = 0;
        for (int e = 1; e <= 20; e++) begin
            step(10'h354, tok_int(2'b00));
            checks++;
            if (locked !== 1'(e >= 10)) begin
                errors++; $display("[TB] FAIL lock_timing cyc %0d: got %0h expected %0h", e, locked, e >= 10);
            end
            if (e == 10) begin
                checks++; if (de !== 1'b0) begin errors++; $display("[TB] FAIL lock_de: got %0h expected 0", de); end
                checks++; if (c !== 2'b00) begin errors++; $display("[TB] FAIL lock_c: got %0h expected 0", c); end
                checks++; if (offset !== 4'd0) begin errors++; $display("[TB] FAIL lock_offset: got %0d expected 0", offset); end
            end
        end
    endtask

    task automatic test_data_decode();
        logic [7:0] bl [4];
        bl = '{8'h00, 8'hFF, 8'h5A, 8'hC3};
        checks++;
        if (tmds_decode(10'h199) !== 11'h4AB) begin
            errors++; $display("[TB] FAIL pkg_decode_199: got %0h expected 4ab", tmds_decode(10'h199));
        end
        step(10'h199, dat_int(8'hAB));
        checks++; if (de !== 1'b0) begin errors++; $display("[TB] FAIL latency_early1: got de %0h expected 0", de); end
        step(10'h354, tok_int(2'b00));
        checks++; if (de !== 1'b0) begin errors++; $display("[TB] FAIL latency_early2: got de %0h expected 0", de); end
        step(10'h354, tok_int(2'b00));
        checks++; if (de !== 1'b1) begin errors++; $display("[TB] FAIL data_de: got %0h expected 1", de); end
        checks++; if (d !== 8'hAB) begin errors++; $display("[TB] FAIL data_d_199: got %0h expected ab", d); end
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL data_locked: got %0h expected 1", locked); end
        for (int k = 0; k < 6; k++) begin
            if (k < 4) step(encode(bl[k], 2'(k)), dat_int(bl[k]));
            else       step(10'h354, tok_int(2'b00));
            checks++;
            if (de !== pipe3[10]) begin
                errors++; $display("[TB] FAIL mode_de %0d: got %0h expected %0h", k, de, pipe3[10]);
            end else if (pipe3[10]) begin
                checks++;
                if (d !== pipe3[7:0]) begin errors++; $display("[TB] FAIL mode_d %0d: got %0h expected %0h", k, d, pipe3[7:0]); end
            end
        end
    endtask

    task automatic test_slip_lock();
        logic [7:0] b;
        do_reset();
        dly = 3;
        for (int i = 0; i < 15000; i++) begin
            if ((i % 1650) < 200) begin
                step(10'h0AB, tok_int(2'b01));
            end else begin
                b = 8'(i * 7 + i / 13);
                step(encode(b, 2'(i >> 3)), dat_int(b));
            end
            if (cyc >= 4095 && cyc <= 12288 && ((cyc % 4096) == 0 || (cyc % 4096) == 4095)) begin
                checks++;
                if (offset !== 4'(cyc / 4096)) begin
                    errors++; $display("[TB] FAIL slip_offset cyc %0d: got %0d expected %0d", cyc, offset, cyc / 4096);
                end
            end
            if (cyc < 13210) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("[TB] FAIL early_lock cyc %0d: got %0h expected 0", cyc, locked); end
            end else begin
                checks++;
                if (locked !== 1'b1) begin
                    errors++; $display("[TB] FAIL slip_locked cyc %0d: got %0h expected 1", cyc, locked);
                end
                checks++;
                if (de !== pipe3[10]) begin
                    errors++; $display("[TB] FAIL slip_de cyc %0d: got %0h expected %0h", cyc, de, pipe3[10]);
                end else if (pipe3[10]) begin
                    checks++;
                    if (d !== pipe3[7:0]) begin errors++; $display("[TB] FAIL slip_d cyc %0d: got %0h expected %0h", cyc, d, pipe3[7:0]); end
                end else begin
                    checks++;
                    if (c !== 2'b01) begin errors++; $display("[TB] FAIL slip_c cyc %0d: got %0h expected 1", cyc, c); end
                end
            end
        end
        checks++; if (offset !== 4'd3) begin errors++; $display("[TB] FAIL slip_final_offset: got %0d expected 3", offset); end
    endtask

    task automatic test_unlock();
        int lock_end;
        logic [7:0] b;
        for (int j = 0; j < 20; j++) step(10'h0AB, tok_int(2'b01));
        lock_end = cyc + 2 + 4096;
        for (int j = 0; j < 5000; j++) begin
            b = 8'(j * 13 + 5);
            step(encode(b, 2'(j)), dat_int(b));
            checks++;
            if (locked !== 1'(cyc < lock_end)) begin
                errors++; $display("[TB] FAIL unlock_timing cyc %0d: got %0h expected %0h", cyc, locked, cyc < lock_end);
            end
        end
        checks++; if (offset !== 4'd3) begin errors++; $display("[TB] FAIL unlock_offset: got %0d expected 3", offset); end
    endtask

    task automatic test_wrap();
        do_reset();
        dly = 9;
        for (int i = 0; i < 10 * 4096 + 2; i++) begin
            step(10'($urandom), 11'h000);
            if (cyc >= 4095 && ((cyc % 4096) == 0 || (cyc % 4096) == 4095)) begin
                checks++;
                if (offset !== 4'((cyc / 4096) % 10)) begin
                    errors++; $display("[TB] FAIL wrap_offset cyc %0d: got %0d expected %0d", cyc, offset, (cyc / 4096) % 10);
                end
                checks++;
                if (locked !== 1'b0) begin errors++; $display("[TB] FAIL wrap_locked cyc %0d: got %0h expected 0", cyc, locked); end
            end
        end
    endtask

    task automatic test_reset_midway();
        do_reset();
        dly = 0;
        repeat (7) step(10'h354, tok_int(2'b00));
        rst = 1'b1;
        step(10'h354, tok_int(2'b00));
        rst = 1'b0; cyc = 0; pipe1 = '0; pipe2 = '0; pipe3 = '0; prev_src = '0;
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL midrun_locked: got %0h expected 0", locked); end
        checks++; if ({de, c, d} !== 11'h000) begin errors++; $display("[TB] FAIL midrun_outputs: got %0h expected 0", {de, c, d}); end
        checks++; if (offset !== 4'd0) begin errors++; $display("[TB] FAIL midrun_offset: got %0d expected 0", offset); end
        for (int e = 1; e <= 12; e++) begin
            step(10'h354, tok_int(2'b00));
            checks++;
            if (locked !== 1'(e >= 10)) begin
                errors++; $display("[TB] FAIL relock_timing cyc %0d: got %0h expected %0h", e, locked, e >= 10);
            end
        end
        repeat (3) step(10'h199, dat_int(8'hAB));
        checks++; if ({de, d} !== 9'h1AB) begin errors++; $display("[TB] FAIL relock_data: got %0h expected 1ab", {de, d}); end
        rst = 1'b1;
        step(10'h199, dat_int(8'hAB));
        rst = 1'b0; cyc = 0;
        checks++; if ({locked, de, c, d} !== 12'h000) begin errors++; $display("[TB] FAIL locked_reset: got %0h expected 0", {locked, de, c, d}); end
        repeat (4095) step(10'($urandom), 11'h000);
        checks++; if (offset !== 4'd0) begin errors++; $display("[TB] FAIL preslip_offset: got %0d expected 0", offset); end
        rst = 1'b1;
        step(10'($urandom), 11'h000);
        rst = 1'b0; cyc = 0;
        checks++; if (offset !== 4'd0) begin errors++; $display("[TB] FAIL midslip_offset: got %0d expected 0", offset); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL midslip_locked: got %0h expected 0", locked); end
        repeat (4095) step(10'($urandom), 11'h000);
        checks++; if (offset !== 4'd0) begin errors++; $display("[TB] FAIL postreset_window: got %0d expected 0", offset); end
        step(10'($urandom), 11'h000);
        checks++; if (offset !== 4'd1) begin errors++; $display("[TB] FAIL postreset_slip: got %0d expected 1", offset); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_data_decode();
        test_slip_lock();
        test_unlock();
        test_wrap();
        test_reset_midway();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
